// File: rtl/spm_port_arbiter_if.sv
// Bundle of every non-clock signal around the scratch-pad port arbiter.
// The arbiter sits on the slave modport. The environment sits on the master
// modport: it plays requesters A and B and the SPM core port.
//   Requester X (X = A, B): reqX/weX/addrX/beX/wdataX in; gntX/rvalidX/rdataX/errX out.
//   SPM core port: spmCs/spmWe/spmAddress/spmByteEnables/dataToSpm out; dataFromSpm in.
interface spm_port_arbiter_if;
  logic        reqA;
  logic        weA;
  logic [17:0] addrA;
  logic [3:0]  beA;
  logic [31:0] wdataA;
  logic        gntA;
  logic        rvalidA;
  logic [31:0] rdataA;
  logic        errA;

  logic        reqB;
  logic        weB;
  logic [17:0] addrB;
  logic [3:0]  beB;
  logic [31:0] wdataB;
  logic        gntB;
  logic        rvalidB;
  logic [31:0] rdataB;
  logic        errB;

  logic        spmCs;
  logic        spmWe;
  logic [17:0] spmAddress;
  logic [3:0]  spmByteEnables;
  logic [31:0] dataToSpm;
  logic [31:0] dataFromSpm;

  modport slave (
    input  reqA, weA, addrA, beA, wdataA,
    output gntA, rvalidA, rdataA, errA,
    input  reqB, weB, addrB, beB, wdataB,
    output gntB, rvalidB, rdataB, errB,
    output spmCs, spmWe, spmAddress, spmByteEnables, dataToSpm,
    input  dataFromSpm
  );

  modport master (
    output reqA, weA, addrA, beA, wdataA,
    input  gntA, rvalidA, rdataA, errA,
    output reqB, weB, addrB, beB, wdataB,
    input  gntB, rvalidB, rdataB, errB,
    input  spmCs, spmWe, spmAddress, spmByteEnables, dataToSpm,
    output dataFromSpm
  );
endinterface

// File: rtl/spm_port_arbiter.sv
// Two-requester arbiter for the single core-side port of the 4 KB scratch-pad.
// Requester A (processor) and requester B (accelerator) share the port. Ties
// are broken round-robin, or in A's favour when FIXED_PRIO_A is set. Each
// grant is tracked through a two-stage return pipeline that lines up with the
// SPM's 2-cycle read latency. The return is then routed back to its owner.
// After MAX_BURST back-to-back SPM cycles, one idle cycle is forced. This lets
// the SPM-internal DMA, which only advances while spmCs=0, make progress.
// Ports:
//   clock - system clock, all state on posedge
//   reset - synchronous, active-high
//   bus   - spm_port_arbiter_if.slave (requester A/B handshakes + SPM core port)
module spm_port_arbiter #(
  parameter int unsigned MAX_BURST      = 8,
  parameter bit          FIXED_PRIO_A   = 1'b0,
  parameter int unsigned SPM_WORDS_LOG2 = 10
) (
  input logic               clock,
  input logic               reset,
  spm_port_arbiter_if.slave bus
);

  localparam logic       OWNER_A     = 1'b0;
  localparam logic       OWNER_B     = 1'b1;
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  // One in-flight access: who owns it, whether data comes back, and whether
  // it was rejected for being out of range.
  typedef struct packed {
    logic valid;
    logic owner;
    logic isRead;
    logic err;
  } ret_t;

  // An address is out of range when any bit above the SPM word index is set.
  function automatic logic addrInRange(input logic [17:0] addr);
    return (addr >> SPM_WORDS_LOG2) == 18'd0;
  endfunction

  logic        grantA_s;
  logic        grantB_s;
  logic        grant_s;
  logic        blocked_s;
  logic        inRange_s;
  logic        spmCs_s;
  logic        selWe_s;
  logic [17:0] selAddr_s;
  logic [3:0]  selBe_s;
  logic [31:0] selWdata_s;
  ret_t        stageLoad_s;

  logic [7:0]  burstCnt_r;
  logic        lastGrant_r;
  ret_t        stage1_r;
  ret_t        stage2_r;

  // Arbitration decision from registered state and the live requests.
  always_comb begin
    blocked_s = (MAX_BURST != 32'd0) && (burstCnt_r == BURST_LIMIT);
    grantA_s  = 1'b0;
    grantB_s  = 1'b0;
    if (reset || blocked_s) begin
      grantA_s = 1'b0;
      grantB_s = 1'b0;
    end else if (bus.reqA && bus.reqB) begin
      // With both requesting, round-robin hands the port to whoever did not win last.
      if (FIXED_PRIO_A || (lastGrant_r == OWNER_B)) begin
        grantA_s = 1'b1;
      end else begin
        grantB_s = 1'b1;
      end
    end else if (bus.reqA) begin
      grantA_s = 1'b1;
    end else if (bus.reqB) begin
      grantB_s = 1'b1;
    end else begin
      grantA_s = 1'b0;
      grantB_s = 1'b0;
    end
    bus.gntA = grantA_s;
    bus.gntB = grantB_s;
  end

  // Select the granted requester's command and classify it.
  always_comb begin
    selWe_s    = 1'b0;
    selAddr_s  = 18'd0;
    selBe_s    = 4'd0;
    selWdata_s = 32'd0;
    case ({grantB_s, grantA_s})
      2'b01: begin
        selWe_s    = bus.weA;
        selAddr_s  = bus.addrA;
        selBe_s    = bus.beA;
        selWdata_s = bus.wdataA;
      end
      2'b10: begin
        selWe_s    = bus.weB;
        selAddr_s  = bus.addrB;
        selBe_s    = bus.beB;
        selWdata_s = bus.wdataB;
      end
      default: begin
        selWe_s    = 1'b0;
        selAddr_s  = 18'd0;
        selBe_s    = 4'd0;
        selWdata_s = 32'd0;
      end
    endcase
    grant_s   = grantA_s | grantB_s;
    inRange_s = addrInRange(selAddr_s);
    spmCs_s   = grant_s & inRange_s;
  end

  // SPM-side drive: only a real in-range access puts anything on the bus.
  always_comb begin
    if (spmCs_s) begin
      bus.spmCs          = 1'b1;
      bus.spmWe          = selWe_s;
      bus.spmAddress     = selAddr_s;
      bus.spmByteEnables = selBe_s;
      bus.dataToSpm      = selWdata_s;
    end else begin
      bus.spmCs          = 1'b0;
      bus.spmWe          = 1'b0;
      bus.spmAddress     = 18'd0;
      bus.spmByteEnables = 4'd0;
      bus.dataToSpm      = 32'd0;
    end
  end

  // Return-pipeline entry for this cycle's grant.
  // An out-of-range grant still completes, but it is flagged with err.
  always_comb begin
    if (grant_s) begin
      stageLoad_s.valid  = 1'b1;
      stageLoad_s.owner  = grantB_s ? OWNER_B : OWNER_A;
      stageLoad_s.isRead = ~selWe_s;
      stageLoad_s.err    = ~inRange_s;
    end else begin
      stageLoad_s = '0;
    end
  end

  // Burst counter: counts back-to-back SPM cycles, cleared by any idle cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      burstCnt_r <= 8'd0;
    end else if (spmCs_s && (burstCnt_r != 8'hFF)) begin
      burstCnt_r <= burstCnt_r + 8'd1;
    end else if (spmCs_s) begin
      burstCnt_r <= burstCnt_r;
    end else begin
      burstCnt_r <= 8'd0;
    end
  end

  // Round-robin memory: starts at B so that A wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      lastGrant_r <= OWNER_B;
    end else if (grantA_s) begin
      lastGrant_r <= OWNER_A;
    end else if (grantB_s) begin
      lastGrant_r <= OWNER_B;
    end else begin
      lastGrant_r <= lastGrant_r;
    end
  end

  // Two-stage return shift register matching the SPM read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage1_r <= '0;
      stage2_r <= '0;
    end else begin
      stage1_r <= stageLoad_s;
      stage2_r <= stage1_r;
    end
  end

  // Route the completion leaving stage 2 to its owner.
  // Read data passes through only for good reads.
  always_comb begin
    bus.rvalidA = 1'b0;
    bus.errA    = 1'b0;
    bus.rdataA  = 32'd0;
    bus.rvalidB = 1'b0;
    bus.errB    = 1'b0;
    bus.rdataB  = 32'd0;
    if (!reset && stage2_r.valid) begin
      if (stage2_r.owner == OWNER_A) begin
        bus.rvalidA = 1'b1;
        bus.errA    = stage2_r.err;
        bus.rdataA  = (stage2_r.isRead && !stage2_r.err) ? bus.dataFromSpm : 32'd0;
      end else begin
        bus.rvalidB = 1'b1;
        bus.errB    = stage2_r.err;
        bus.rdataB  = (stage2_r.isRead && !stage2_r.err) ? bus.dataFromSpm : 32'd0;
      end
    end else begin
      bus.rvalidA = 1'b0;
      bus.rvalidB = 1'b0;
    end
  end

endmodule

// File: tb/tb_spm_port_arbiter.sv
// Self-checking bench for spm_port_arbiter.
// The bench plays requesters A and B, an SPM with 2-cycle read latency and a
// DMA engine that only writes while spmCs=0. Each request is a record that
// carries its own expected completion. That record moves into a scoreboard
// when the request is granted. The scoreboard entry is popped and compared
// when rvalid appears.
module tb_spm_port_arbiter;

  typedef struct {
    bit          port;      // 0 = A, 1 = B
    bit          we;
    logic [17:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          expErr;
    logic [31:0] expRdata;
  } vec_t;

  typedef struct {
    bit          owner;
    bit          err;
    logic [31:0] rdata;
    int          due;
  } sb_t;

  logic clock;
  logic reset;
  spm_port_arbiter_if bus ();

  spm_port_arbiter #(
    .MAX_BURST(8),
    .FIXED_PRIO_A(1'b0),
    .SPM_WORDS_LOG2(10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  vec_t qA[$];
  vec_t qB[$];
  sb_t  sb[$];
  bit   grantLog[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  logic [31:0] mem [1024];
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        dmaReq;
  logic        dmaDone;
  int          dmaDoneCyc;
  localparam logic [9:0]  DMA_ADDR = 10'h200;
  localparam logic [31:0] DMA_DATA = 32'h5A5A1234;

  function automatic logic [31:0] initWord(input int i);
    if (i == 5) return 32'h12345678;
    else if (i == 16) return 32'h11223344;
    else return 32'hC0DE0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle counter.
  always @(posedge clock) cyc <= cyc + 1;

  // SPM model with 2-cycle read latency, plus the DMA that only writes on idle cycles.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= initWord(i);
      dmaDone <= 1'b0;
    end else if (bus.spmCs && bus.spmWe) begin
      for (int b = 0; b < 4; b++)
        if (bus.spmByteEnables[b]) mem[bus.spmAddress[9:0]][8*b +: 8] <= bus.dataToSpm[8*b +: 8];
    end else if (!bus.spmCs && dmaReq && !dmaDone) begin
      mem[DMA_ADDR] <= DMA_DATA;
      dmaDone       <= 1'b1;
      dmaDoneCyc    <= cyc;
    end
    rd1 <= (bus.spmCs && !bus.spmWe) ? mem[bus.spmAddress[9:0]] : 32'hBAD0BAD0;
    rd2 <= rd1;
  end
  assign bus.dataFromSpm = rd2;

  // Grant-cycle checks on the SPM drive, then hand the expectation to the scoreboard.
  task automatic onGrant(input vec_t v, input logic otherGnt);
    chk("singleGnt", {31'd0, otherGnt}, 32'd0);
    chk("spmCs", {31'd0, bus.spmCs}, {31'd0, !v.expErr});
    if (!v.expErr) begin
      chk("spmAddress", {14'd0, bus.spmAddress}, {14'd0, v.addr});
      chk("spmWe", {31'd0, bus.spmWe}, {31'd0, v.we});
      if (v.we) begin
        chk("spmByteEnables", {28'd0, bus.spmByteEnables}, {28'd0, v.be});
        chk("dataToSpm", bus.dataToSpm, v.wdata);
      end
    end
    sb.push_back('{owner: v.port, err: v.expErr, rdata: v.expRdata, due: cyc + 2});
    grantLog.push_back(v.port);
  endtask

  // Requester A driver: hold each request until granted.
  initial begin
    bus.reqA = 1'b0; bus.weA = 1'b0; bus.addrA = 18'd0; bus.beA = 4'd0; bus.wdataA = 32'd0;
    forever begin
      @(posedge clock); #1;
      if (qA.size() != 0) begin
        bus.reqA = 1'b1; bus.weA = qA[0].we; bus.addrA = qA[0].addr;
        bus.beA = qA[0].be; bus.wdataA = qA[0].wdata;
      end else begin
        bus.reqA = 1'b0; bus.weA = 1'b0; bus.addrA = 18'd0; bus.beA = 4'd0; bus.wdataA = 32'd0;
      end
      @(negedge clock);
      if (bus.reqA && bus.gntA) begin
        onGrant(qA[0], bus.gntB);
        void'(qA.pop_front());
      end
    end
  end

  // Requester B driver.
  initial begin
    bus.reqB = 1'b0; bus.weB = 1'b0; bus.addrB = 18'd0; bus.beB = 4'd0; bus.wdataB = 32'd0;
    forever begin
      @(posedge clock); #1;
      if (qB.size() != 0) begin
        bus.reqB = 1'b1; bus.weB = qB[0].we; bus.addrB = qB[0].addr;
        bus.beB = qB[0].be; bus.wdataB = qB[0].wdata;
      end else begin
        bus.reqB = 1'b0; bus.weB = 1'b0; bus.addrB = 18'd0; bus.beB = 4'd0; bus.wdataB = 32'd0;
      end
      @(negedge clock);
      if (bus.reqB && bus.gntB) begin
        onGrant(qB[0], bus.gntA);
        void'(qB.pop_front());
      end
    end
  end

  task automatic handleRet(input bit port, input logic err, input logic [31:0] data);
    sb_t e;
    if (sb.size() == 0) begin
      failNow(port ? "unexpectedRvalidB" : "unexpectedRvalidA");
    end else begin
      e = sb.pop_front();
      chk("owner", {31'd0, port}, {31'd0, e.owner});
      chk("latency", cyc, e.due);
      chk("err", {31'd0, err}, {31'd0, e.err});
      chk("rdata", data, e.rdata);
    end
  endtask

  // Completion monitor: pops the scoreboard and checks that idle ports stay quiet.
  initial begin
    forever begin
      @(negedge clock);
      chk("oneRvalid", {31'd0, bus.rvalidA & bus.rvalidB}, 32'd0);
      if (bus.rvalidA) handleRet(1'b0, bus.errA, bus.rdataA);
      else chk("idleA", bus.rdataA | {31'd0, bus.errA}, 32'd0);
      if (bus.rvalidB) handleRet(1'b1, bus.errB, bus.rdataB);
      else chk("idleB", bus.rdataB | {31'd0, bus.errB}, 32'd0);
      if (sb.size() != 0 && sb[0].due < cyc) begin
        failNow("lostCompletion");
        void'(sb.pop_front());
      end
    end
  end

  // Request must be held until granted.
  reqHeldA: assert property (@(posedge clock) disable iff (reset) (bus.reqA && !bus.gntA) |=> bus.reqA)
    else $error("protocol: reqA dropped before gntA");
  reqHeldB: assert property (@(posedge clock) disable iff (reset) (bus.reqB && !bus.gntB) |=> bus.reqB)
    else $error("protocol: reqB dropped before gntB");

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((qA.size() != 0 || qB.size() != 0 || sb.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (qA.size() != 0 || qB.size() != 0 || sb.size() != 0) begin
      failNow("idleTimeout");
      qA.delete(); qB.delete(); sb.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic checkQuiet(input string name);
    chk(name, {28'd0, bus.rvalidA, bus.rvalidB, bus.errA, bus.errB}, 32'd0);
  endtask

  vec_t vecs[9];

  // Main sequence.
  initial begin
    int n, p, ones, firstCyc;
    bit started;
    vecs[0] = '{1'b0, 1'b0, 18'h00005, 4'hF, 32'h0,        1'b0, 32'h12345678};
    vecs[1] = '{1'b0, 1'b1, 18'h00010, 4'h3, 32'hAABBCCDD, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 18'h00010, 4'hF, 32'h0,        1'b0, 32'h1122CCDD};
    vecs[3] = '{1'b1, 1'b0, 18'h00400, 4'hF, 32'h0,        1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 18'h003FF, 4'hF, 32'h0,        1'b0, 32'hC0DE03FF};
    vecs[5] = '{1'b0, 1'b1, 18'h20000, 4'hF, 32'h01020304, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 18'h00020, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 18'h00020, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[8] = '{1'b0, 1'b0, 18'h00020, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF};

    reset  = 1'b1;
    dmaReq = 1'b0;
    repeat (3) @(negedge clock);
    chk("resetGnt", {30'd0, bus.gntA, bus.gntB}, 32'd0);
    chk("resetSpm", {30'd0, bus.spmCs, bus.spmWe}, 32'd0);
    checkQuiet("resetRet");
    chk("resetRdata", bus.rdataA | bus.rdataB, 32'd0);
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    chk("idleSpmCs", {31'd0, bus.spmCs}, 32'd0);

    // Both requesters stream reads: grants must alternate starting with A.
    grantLog.delete();
    for (int i = 0; i < 4; i++) begin
      qA.push_back('{1'b0, 1'b0, 18'h40 + 18'(i), 4'hF, 32'h0, 1'b0, 32'hC0DE0040 + 32'(i)});
      qB.push_back('{1'b1, 1'b0, 18'h80 + 18'(i), 4'hF, 32'h0, 1'b0, 32'hC0DE0080 + 32'(i)});
    end
    waitIdle(60);
    chk("altCount", grantLog.size(), 32'd8);
    for (int i = 0; i < 8 && i < grantLog.size(); i++)
      chk("altOrder", {31'd0, grantLog[i]}, 32'(i % 2));

    // Single transactions from the table.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].port) qB.push_back(vecs[i]);
      else qA.push_back(vecs[i]);
      waitIdle(30);
    end

    // A streams 20 reads: expect 8 on / 1 idle; the DMA lands in the first idle cycle.
    for (int i = 0; i < 20; i++)
      qA.push_back('{1'b0, 1'b0, 18'h100 + 18'(i), 4'hF, 32'h0, 1'b0, 32'hC0DE0100 + 32'(i)});
    started = 1'b0; p = 0; ones = 0; n = 0; firstCyc = 0;
    while (ones < 20 && n < 80) begin
      @(negedge clock);
      n++;
      if (!started && bus.spmCs) begin
        started  = 1'b1;
        firstCyc = cyc;
        dmaReq   = 1'b1;
      end
      if (started) begin
        chk("burstCs", {31'd0, bus.spmCs}, {31'd0, (p % 9) != 8});
        if (bus.spmCs) ones++;
        p++;
      end
    end
    if (ones < 20) failNow("burstTimeout");
    waitIdle(40);
    chk("dmaDone", {31'd0, dmaDone}, 32'd1);
    chk("dmaCycle", dmaDoneCyc, firstCyc + 8);
    qA.push_back('{1'b0, 1'b0, 18'(DMA_ADDR), 4'hF, 32'h0, 1'b0, DMA_DATA});
    waitIdle(30);

    // Reset the cycle after a grant: the in-flight return must vanish.
    grantLog.delete();
    qA.push_back('{1'b0, 1'b0, 18'h007, 4'hF, 32'h0, 1'b0, 32'hC0DE0007});
    n = 0;
    while (grantLog.size() == 0 && n < 20) begin
      @(posedge clock); #2;
      n++;
    end
    if (grantLog.size() == 0) failNow("midGrantTimeout");
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    checkQuiet("midResetN1");
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    checkQuiet("midResetN2");
    @(negedge clock);
    checkQuiet("midResetN3");

    // First tie after reset goes to A.
    grantLog.delete();
    qA.push_back('{1'b0, 1'b0, 18'h030, 4'hF, 32'h0, 1'b0, 32'hC0DE0030});
    qB.push_back('{1'b1, 1'b0, 18'h031, 4'hF, 32'h0, 1'b0, 32'hC0DE0031});
    waitIdle(30);
    chk("tieCount", grantLog.size(), 32'd2);
    if (grantLog.size() != 0) chk("tieAfterReset", {31'd0, grantLog[0]}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #400000;
    $display("FAIL watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
